// File: rtl/rf_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter_pkg : shared widths and FSM encoding for the RF write arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rf_wr_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] INIT_FIRST_IDX = 5'd1;
  localparam logic [REG_IDX_W-1:0] INIT_LAST_IDX  = 5'd31;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin grant with a one-bit last-grant history
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic r_last_grant;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable && !rst) begin
      grant0 = valid0 && (!valid1 || r_last_grant);
      grant1 = valid1 && (!valid0 || !r_last_grant);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (grant0) begin
      r_last_grant <= 1'b0;
    end else if (grant1) begin
      r_last_grant <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter : clears r1..r31 after reset, then arbitrates two RF writers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned INIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [REG_IDX_W-1:0] req0_addr,
  input  logic [REG_IDX_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic                 rf_wen,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 init_done
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [REG_IDX_W-1:0] r_counter;
  logic [REG_IDX_W-1:0] w_counter_nxt;
  logic                 r_init_done;
  logic                 r_rf_wen;
  logic [REG_IDX_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0]    r_rf_wdata;
  logic                 w_rf_wen_nxt;
  logic [REG_IDX_W-1:0] w_rf_waddr_nxt;
  logic [DATA_W-1:0]    w_rf_wdata_nxt;
  logic                 w_arb_enable;
  logic                 w_grant0;
  logic                 w_grant1;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (w_arb_enable),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (w_grant0),
    .grant1 (w_grant1)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_counter_nxt  = r_counter;
    w_rf_wen_nxt   = 1'b0;
    w_rf_waddr_nxt = r_rf_waddr;
    w_rf_wdata_nxt = r_rf_wdata;
    w_arb_enable   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_rf_wen_nxt   = 1'b1;
        w_rf_waddr_nxt = r_counter;
        w_rf_wdata_nxt = '0;
        w_counter_nxt  = r_counter + 5'd1;
        if (r_counter == INIT_LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_arb_enable = 1'b1;
        // r0 is hardwired zero: the handshake completes but nothing is written.
        if (w_grant0) begin
          w_rf_wen_nxt   = (req0_addr != '0);
          w_rf_waddr_nxt = req0_addr;
          w_rf_wdata_nxt = req0_data;
        end else if (w_grant1) begin
          w_rf_wen_nxt   = (req1_addr != '0);
          w_rf_waddr_nxt = req1_addr;
          w_rf_wdata_nxt = req1_data;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      r_counter   <= INIT_FIRST_IDX;
      // Without a clear sequence the block is in RUN straight out of reset.
      r_init_done <= (INIT_EN == 0);
      r_rf_wen    <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      r_rf_wen    <= w_rf_wen_nxt;
      r_rf_waddr  <= w_rf_waddr_nxt;
      r_rf_wdata  <= w_rf_wdata_nxt;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign init_done  = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wr_arbiter : vector table, directed corners and random traffic vs model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rf_wen, init_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        rst_b;
  logic        b_v0, b_v1;
  logic [4:0]  b_a0, b_a1;
  logic [31:0] b_d0, b_d1;
  logic        b_r0, b_r1, b_wen, b_done;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;

  rf_wr_arbiter #(.INIT_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_done(init_done)
  );

  rf_wr_arbiter #(.INIT_EN(0)) u_dut_noinit (
    .clk(clk), .rst(rst_b),
    .req0_valid(b_v0), .req1_valid(b_v1),
    .req0_addr(b_a0), .req1_addr(b_a1),
    .req0_data(b_d0), .req1_data(b_d1),
    .req0_ready(b_r0), .req1_ready(b_r1),
    .rf_wen(b_wen), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
    .init_done(b_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: INIT is just "cycles of clearing left", RUN is a
  // fairness rule on who was served last.
  int          m_left;
  int          m_last;
  int          m_win;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_done;
  logic        obs_r0, obs_r1;

  typedef struct {
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        r0, r1;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left  = 31;
    m_last  = 1;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_done  = 1'b0;
  endtask

  task automatic step(input logic v0, input logic v1, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    int win;
    req0_valid = v0; req1_valid = v1;
    req0_addr  = a0; req1_addr  = a1;
    req0_data  = d0; req1_data  = d1;
    #1;
    win = -1;
    if (m_left == 0) begin
      if (v0 && v1)  win = 1 - m_last;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    chk("ready0", {31'd0, req0_ready}, {31'd0, win == 0});
    chk("ready1", {31'd0, req1_ready}, {31'd0, win == 1});
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    m_win  = win;
    if (m_left > 0) begin
      m_wen   = 1'b1;
      m_waddr = 5'(32 - m_left);
      m_wdata = '0;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (win == 0) begin
      m_last = 0; m_wen = (a0 != 0); m_waddr = a0; m_wdata = d0;
    end else if (win == 1) begin
      m_last = 1; m_wen = (a1 != 0); m_waddr = a1; m_wdata = d1;
    end else begin
      m_wen = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_wen",    {31'd0, rf_wen},    {31'd0, m_wen});
    chk("rf_waddr",  {27'd0, rf_waddr},  {27'd0, m_waddr});
    chk("rf_wdata",  rf_wdata,           m_wdata);
    chk("init_done", {31'd0, init_done}, {31'd0, m_done});
  endtask

  logic        p0, p1;
  logic [4:0]  pa0, pa1;
  logic [31:0] pd0, pd1;

  initial begin
    // v0 v1 a0 a1 d0 d1 | r0 r1 | wen waddr wdata (after the edge)
    tbl[0] = '{1'b0, 1'b1, 5'd0, 5'd5, 32'h0,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22,       1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
    tbl[2] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22,       1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
    tbl[3] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22,       1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
    tbl[4] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22,       1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF};
    tbl[6] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h33, 32'h44,       1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    tbl[7] = '{1'b0, 1'b0, 5'd3, 5'd4, 32'h33, 32'h44,       1'b0, 1'b0, 1'b0, 5'd4, 32'h44};
    tbl[8] = '{1'b1, 1'b1, 5'd7, 5'd7, 32'hA,  32'hB,        1'b1, 1'b0, 1'b1, 5'd7, 32'hA};
    tbl[9] = '{1'b1, 1'b1, 5'd7, 5'd7, 32'hA,  32'hB,        1'b0, 1'b1, 1'b1, 5'd7, 32'hB};

    rst = 1'b1; rst_b = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 5'd3; req1_addr = 5'd4; req0_data = 32'h1; req1_data = 32'h2;
    b_v0 = 1'b1; b_v1 = 1'b0; b_a0 = 5'd9; b_a1 = 5'd0; b_d0 = 32'h99; b_d1 = 32'h0;
    model_reset();

    @(posedge clk); #1;
    chk("rst_wen",    {31'd0, rf_wen},     32'd0);
    chk("rst_waddr",  {27'd0, rf_waddr},   32'd0);
    chk("rst_wdata",  rf_wdata,            32'd0);
    chk("rst_done",   {31'd0, init_done},  32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rstb_ready", {31'd0, b_r0},       32'd0);

    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 5'd3, 5'd4, 32'h1, 32'h2);

    // Counter is at 10 here; reset lands between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("async_wen",    {31'd0, rf_wen},     32'd0);
    chk("async_waddr",  {27'd0, rf_waddr},   32'd0);
    chk("async_done",   {31'd0, init_done},  32'd0);
    chk("async_ready0", {31'd0, req0_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 5'd3, 5'd4, 32'h1, 32'h2);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d_r0", i),    {31'd0, obs_r0},   {31'd0, tbl[i].r0});
      chk($sformatf("tbl%0d_r1", i),    {31'd0, obs_r1},   {31'd0, tbl[i].r1});
      chk($sformatf("tbl%0d_wen", i),   {31'd0, rf_wen},   {31'd0, tbl[i].wen});
      chk($sformatf("tbl%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].waddr});
      chk($sformatf("tbl%0d_wdata", i), rf_wdata,          tbl[i].wdata);
    end

    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(1, 0) != 0)) begin
        p0  = 1'b1;
        pa0 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        pd0 = $urandom();
      end
      if (!p1 && ($urandom_range(1, 0) != 0)) begin
        p1  = 1'b1;
        pa1 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        pd1 = $urandom();
      end
      step(p0, p1, pa0, pa1, pd0, pd1);
      if (m_win == 0) p0 = 1'b0;
      if (m_win == 1) p1 = 1'b0;
    end

    // No-clear variant: live as soon as reset drops.
    @(negedge clk);
    chk("b_rst_ready0", {31'd0, b_r0}, 32'd0);
    rst_b = 1'b0;
    #1;
    chk("b_done",   {31'd0, b_done}, 32'd1);
    chk("b_ready0", {31'd0, b_r0},   32'd1);
    chk("b_ready1", {31'd0, b_r1},   32'd0);
    @(posedge clk); #1;
    chk("b_wen",   {31'd0, b_wen},   32'd1);
    chk("b_waddr", {27'd0, b_waddr}, 32'd9);
    chk("b_wdata", b_wdata,          32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
